// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM pipeline stage: word type, FSM states,
// load/store funct3 encodings and the pipeline control word.
package mem_stage_pkg;

    typedef logic [31:0] rv32i_word;

    typedef enum logic {IDLE, ACCESS} state_e;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_e;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_e;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic       load_regfile;
    } ctrl_t;

    // Instruction fields the stage keeps while a memory access is outstanding.
    typedef struct packed {
        rv32i_word pc;
        rv32i_word alu_out;
        rv32i_word rs2;
        logic      br_en;
        ctrl_t     ctrl;
    } exmem_t;

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs, data-memory port and MEM/WB outputs of the MEM stage.
// The stage itself uses the slave view; its environment uses the master view.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic      exmem_valid;
    ctrl_t     exmem_ctrl_word;
    rv32i_word exmem_pc;
    rv32i_word exmem_alu_out;
    rv32i_word exmem_rs2_out;
    logic      exmem_br_en;

    logic      dmem_read;
    logic      dmem_write;
    rv32i_word dmem_address;
    logic [3:0] dmem_mbe;
    rv32i_word dmem_wdata;
    rv32i_word dmem_rdata;
    logic      dmem_resp;

    logic      mem_stall;

    logic      memwb_valid;
    ctrl_t     memwb_ctrl_word;
    rv32i_word memwb_pc;
    rv32i_word memwb_alu_out;
    logic      memwb_br_en;
    rv32i_word memwb_rdata;
    logic      memwb_misaligned;

    modport slave (
        input  exmem_valid, exmem_ctrl_word, exmem_pc, exmem_alu_out,
               exmem_rs2_out, exmem_br_en, dmem_rdata, dmem_resp,
        output dmem_read, dmem_write, dmem_address, dmem_mbe, dmem_wdata,
               mem_stall, memwb_valid, memwb_ctrl_word, memwb_pc,
               memwb_alu_out, memwb_br_en, memwb_rdata, memwb_misaligned
    );

    modport master (
        output exmem_valid, exmem_ctrl_word, exmem_pc, exmem_alu_out,
               exmem_rs2_out, exmem_br_en, dmem_rdata, dmem_resp,
        input  dmem_read, dmem_write, dmem_address, dmem_mbe, dmem_wdata,
               mem_stall, memwb_valid, memwb_ctrl_word, memwb_pc,
               memwb_alu_out, memwb_br_en, memwb_rdata, memwb_misaligned
    );

endinterface

// File: rtl/mem_align.sv
// Byte-lane steering for loads and stores: byte enables, store data shift,
// load extraction/extension and misalignment detection.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic [1:0] offset_i,
    input  logic       is_load_i,
    input  logic       is_store_i,
    input  rv32i_word  rs2_i,
    input  rv32i_word  rdata_i,
    output logic [3:0] mbe_o,
    output rv32i_word  wdata_o,
    output rv32i_word  load_o,
    output logic       misaligned_o
);

    logic [4:0] shamt;
    rv32i_word  shifted;

    assign shamt   = {offset_i, 3'b000};
    assign wdata_o = rs2_i << shamt;
    assign shifted = rdata_i >> shamt;

    assign misaligned_o = (is_load_i | is_store_i) &
                          (((funct3_i[1:0] == 2'b01) & offset_i[0]) |
                           ((funct3_i[1:0] == 2'b10) & (offset_i != 2'b00)));

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        mbe_o = 4'b0000;
        if (is_store_i) begin
            case (funct3_i)
                SB:      mbe_o = 4'b0001 << offset_i;
                SH:      mbe_o = 4'b0011 << offset_i;
                default: mbe_o = 4'b1111;
            endcase
        end
    end

    always_comb begin
        load_o = shifted;
        case (funct3_i)
            LB:      load_o = {{24{shifted[7]}}, shifted[7:0]};
            LH:      load_o = {{16{shifted[15]}}, shifted[15:0]};
            LBU:     load_o = {24'b0, shifted[7:0]};
            LHU:     load_o = {16'b0, shifted[15:0]};
            default: load_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: passes non-memory ops through in one cycle and holds
// the pipeline while a data-memory access waits for its response.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    mem_stage_if.slave mem_if
);

    state_e     state_q, state_d;
    exmem_t     live, cur, lat_q, lat_d;
    logic       valid_q, valid_d, br_q, br_d, mis_q, mis_d;
    ctrl_t      ctrl_q, ctrl_d;
    rv32i_word  pc_q, pc_d, alu_q, alu_d, rdata_q, rdata_d;
    logic       cur_load, cur_store, live_mem_op, stall;
    logic [3:0] a_mbe;
    rv32i_word  a_wdata, a_load;
    logic       a_mis;

    assign live = '{pc:      mem_if.exmem_pc,
                    alu_out: mem_if.exmem_alu_out,
                    rs2:     mem_if.exmem_rs2_out,
                    br_en:   mem_if.exmem_br_en,
                    ctrl:    mem_if.exmem_ctrl_word};

    // While an access is outstanding the lanes are steered from the latched copy.
    assign cur         = (state_q == ACCESS) ? lat_q : live;
    assign cur_load    = cur.ctrl.mem_read;
    assign cur_store   = cur.ctrl.mem_write & ~cur.ctrl.mem_read;
    assign live_mem_op = mem_if.exmem_valid &
                         (live.ctrl.mem_read | live.ctrl.mem_write);

    mem_align u_align (
        .funct3_i     (cur.ctrl.funct3),
        .offset_i     (cur.alu_out[1:0]),
        .is_load_i    (cur_load),
        .is_store_i   (cur_store),
        .rs2_i        (cur.rs2),
        .rdata_i      (mem_if.dmem_rdata),
        .mbe_o        (a_mbe),
        .wdata_o      (a_wdata),
        .load_o       (a_load),
        .misaligned_o (a_mis)
    );

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        valid_d = 1'b0;
        ctrl_d  = ctrl_q;
        pc_d    = pc_q;
        alu_d   = alu_q;
        br_d    = br_q;
        rdata_d = rdata_q;
        mis_d   = mis_q;
        stall   = 1'b0;
        mem_if.dmem_read    = 1'b0;
        mem_if.dmem_write   = 1'b0;
        mem_if.dmem_address = '0;
        mem_if.dmem_mbe     = 4'b0000;
        mem_if.dmem_wdata   = '0;

        case (state_q)
            IDLE: begin
                if (live_mem_op && !a_mis) begin
                    lat_d   = live;
                    state_d = ACCESS;
                    stall   = 1'b1;
                end else if (mem_if.exmem_valid) begin
                    valid_d = 1'b1;
                    ctrl_d  = live.ctrl;
                    ctrl_d.load_regfile = live.ctrl.load_regfile & ~a_mis;
                    pc_d    = live.pc;
                    alu_d   = live.alu_out;
                    br_d    = live.br_en;
                    rdata_d = '0;
                    mis_d   = a_mis;
                end
            end
            ACCESS: begin
                mem_if.dmem_read    = cur_load;
                mem_if.dmem_write   = cur_store;
                mem_if.dmem_address = {lat_q.alu_out[31:2], 2'b00};
                mem_if.dmem_mbe     = a_mbe;
                mem_if.dmem_wdata   = cur_store ? a_wdata : '0;
                if (mem_if.dmem_resp) begin
                    valid_d = 1'b1;
                    ctrl_d  = lat_q.ctrl;
                    pc_d    = lat_q.pc;
                    alu_d   = lat_q.alu_out;
                    br_d    = lat_q.br_en;
                    rdata_d = cur_load ? a_load : '0;
                    mis_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so all update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            lat_q   <= '0;
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            pc_q    <= '0;
            alu_q   <= '0;
            br_q    <= 1'b0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            pc_q    <= pc_d;
            alu_q   <= alu_d;
            br_q    <= br_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
        end
    end

    // Upstream may still hold a memory op during reset; the stall must stay low.
    assign mem_if.mem_stall        = stall & rst;
    assign mem_if.memwb_valid      = valid_q;
    assign mem_if.memwb_ctrl_word  = ctrl_q;
    assign mem_if.memwb_pc         = pc_q;
    assign mem_if.memwb_alu_out    = alu_q;
    assign mem_if.memwb_br_en      = br_q;
    assign mem_if.memwb_rdata      = rdata_q;
    assign mem_if.memwb_misaligned = mis_q;

    a_no_read_write: assert property (@(posedge clk) disable iff (!rst)
        !(mem_if.exmem_valid && mem_if.exmem_ctrl_word.mem_read &&
          mem_if.exmem_ctrl_word.mem_write))
        else $error("mem_stage: mem_read and mem_write both set");

endmodule
